// File: rtl/wave_gen_dds.sv
// DDS waveform generator: phase accumulator with four shapes and wrap-staged sel/duty changes.
// Optional WAVEGEN_AMP_EN adds an amp input and one extra output stage that scales the sample.
module wave_gen_dds #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [1:0]         sel,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [DATA_W-1:0]  duty,
`ifdef WAVEGEN_AMP_EN
    input  logic [DATA_W-1:0]  amp,
`endif
    output logic [DATA_W-1:0]  out,
    output logic               wrap,
    output logic               pending
);

    localparam int unsigned SUM_W  = PHASE_W + 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [DATA_W-1:0] DUTY_RST = {1'b1, {(DATA_W-1){1'b0}}};

    logic [PHASE_W-1:0] phase;
    logic [1:0]         active_sel;
    logic [DATA_W-1:0]  active_duty;
    logic               carry_q;
    logic               wrap_s1;
    logic [DATA_W-1:0]  shape_q;
    logic [SUM_W-1:0]   sum;
    logic               carry;
    logic [DATA_W-1:0]  p;
    logic [DATA_W-1:0]  t;
    logic               msb;
    logic [DATA_W-1:0]  shape;

    assign sum   = SUM_W'(phase) + SUM_W'(freq_word);
    assign carry = sum[PHASE_W];
    assign p     = phase[PHASE_W-1 -: DATA_W];
    assign t     = phase[PHASE_W-2 -: DATA_W];
    assign msb   = phase[PHASE_W-1];

    assign pending = (sel != active_sel) || (duty != active_duty);

    // Shape decode from the current phase and the active (not requested) settings
    always_comb begin
        shape = '0;
        case (active_sel)
            2'b00:   shape = p;
            2'b01:   shape = msb ? ~t : t;
            2'b10:   shape = (p < active_duty) ? '1 : '0;
            default: shape = ~p;
        endcase
    end

    // carry_q marks the edge where phase wrapped; wrap_s1 lines the pulse up with the wrapped sample
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            active_sel  <= 2'b00;
            active_duty <= DUTY_RST;
            carry_q     <= 1'b0;
            wrap_s1     <= 1'b0;
            shape_q     <= '0;
        end else begin
            if (clr) begin
                phase   <= '0;
                carry_q <= 1'b0;
            end else if (en) begin
                phase   <= sum[PHASE_W-1:0];
                carry_q <= carry;
            end else begin
                carry_q <= 1'b0;
            end
            if (clr || !en || carry) begin
                active_sel  <= sel;
                active_duty <= duty;
            end
            shape_q <= shape;
            wrap_s1 <= carry_q;
        end
    end

`ifdef WAVEGEN_AMP_EN
    logic [PROD_W-1:0] prod;

    assign prod = PROD_W'(shape_q) * PROD_W'(amp);

    // Amplitude stage: keep the upper half of the full product
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            out  <= DATA_W'(prod >> DATA_W);
            wrap <= wrap_s1;
        end
    end
`else
    assign out  = shape_q;
    assign wrap = wrap_s1;
`endif

endmodule

// File: tb/tb_wave_gen_dds.sv
// Scoreboard bench for wave_gen_dds: driver pushes model predictions, monitor compares each cycle.
module tb_wave_gen_dds;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [1:0]  sel;
    logic [15:0] freq_word;
    logic [7:0]  duty, amp;
    logic [7:0]  out;
    logic        wrap, pending;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    logic [9:0] exp_q[$];

    // Reference state: phase as an integer, settings in force, and history needed for latency
    int         m_phase;
    logic [1:0] m_sel;
    int         m_duty;
    int         m_wrap_evt;
    int         m_o1, m_o2, m_w1, m_w2;

    always #5 clk = ~clk;

    wave_gen_dds #(.DATA_W(8), .PHASE_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sel(sel),
        .freq_word(freq_word), .duty(duty),
`ifdef WAVEGEN_AMP_EN
        .amp(amp),
`endif
        .out(out), .wrap(wrap), .pending(pending)
    );

    function automatic int shape_of(input int ph, input logic [1:0] s, input int d);
        int q;
        q = ph / 256;
        case (s)
            2'd0:    return q;
            2'd1:    return (ph < 32768) ? ph / 128 : 255 - (ph - 32768) / 128;
            2'd2:    return (q < d) ? 255 : 0;
            default: return 255 - q;
        endcase
    endfunction

    task automatic model_step();
        int total, n_o1, n_o2, n_w1, n_w2;
        if (rst) begin
            m_phase = 0; m_sel = 2'd0; m_duty = 128; m_wrap_evt = 0;
            m_o1 = 0; m_o2 = 0; m_w1 = 0; m_w2 = 0;
        end else begin
            n_o1 = shape_of(m_phase, m_sel, m_duty);
            n_w1 = m_wrap_evt;
            n_o2 = (m_o1 * int'(amp)) / 256;
            n_w2 = m_w1;
            total = m_phase + int'(freq_word);
            if (clr) begin
                m_phase = 0; m_wrap_evt = 0;
                m_sel = sel; m_duty = int'(duty);
            end else if (en) begin
                m_phase = total % 65536;
                m_wrap_evt = (total >= 65536) ? 1 : 0;
                if (total >= 65536) begin m_sel = sel; m_duty = int'(duty); end
            end else begin
                m_wrap_evt = 0;
                m_sel = sel; m_duty = int'(duty);
            end
            m_o1 = n_o1; m_o2 = n_o2; m_w1 = n_w1; m_w2 = n_w2;
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic c, input logic [1:0] s,
                       input logic [15:0] f, input logic [7:0] d, input logic [7:0] a);
        logic [7:0] eo;
        logic       ew, ep;
        @(negedge clk);
        rst = r; en = e; clr = c; sel = s; freq_word = f; duty = d; amp = a;
        model_step();
`ifdef WAVEGEN_AMP_EN
        eo = 8'(m_o2); ew = (m_w2 != 0);
`else
        eo = 8'(m_o1); ew = (m_w1 != 0);
`endif
        ep = (s != m_sel) || (int'(d) != m_duty);
        exp_q.push_back({eo, ew, ep});
    endtask

    task automatic run(input int n, input logic [1:0] s, input logic [15:0] f,
                       input logic [7:0] d, input logic [7:0] a);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, s, f, d, a);
    endtask

    task automatic do_reset(input logic [1:0] s, input logic [7:0] d);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, s, 16'h0000, d, 8'd255);
    endtask

    // Monitor: one output sample per clock, compared against the oldest prediction
    always @(posedge clk) begin
        logic [9:0] e;
        #1;
        cyc_no++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({out, wrap, pending} !== e) begin
                n_fail++;
                $display("FAIL sample cyc=%0d out=%0d exp=%0d wrap=%0b exp=%0b pending=%0b exp=%0b",
                         cyc_no, out, e[9:2], wrap, e[1], pending, e[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; sel = 2'd0;
        freq_word = 16'h0000; duty = 8'd128; amp = 8'd255;

        // Sawtooth at one code per cycle, across two wraps
        do_reset(2'd0, 8'd128);
        run(520, 2'd0, 16'h0100, 8'd128, 8'd255);

        // Triangle, applied while idle right after reset
        do_reset(2'd0, 8'd128);
        cyc(1'b0, 1'b0, 1'b0, 2'd1, 16'h0100, 8'd128, 8'd255);
        run(300, 2'd1, 16'h0100, 8'd128, 8'd255);

        // Square with duty 64, then duty 0 staged to the next period
        do_reset(2'd0, 8'd128);
        cyc(1'b0, 1'b0, 1'b0, 2'd2, 16'h0100, 8'd64, 8'd255);
        run(300, 2'd2, 16'h0100, 8'd64, 8'd255);
        run(300, 2'd2, 16'h0100, 8'd0, 8'd255);

        // Mid-period sel change waits for the wrap; idle change applies at once
        do_reset(2'd0, 8'd128);
        run(128, 2'd0, 16'h0100, 8'd128, 8'd255);
        run(200, 2'd1, 16'h0100, 8'd128, 8'd255);
        cyc(1'b0, 1'b0, 1'b0, 2'd3, 16'h0100, 8'd128, 8'd255);
        cyc(1'b0, 1'b0, 1'b0, 2'd3, 16'h0100, 8'd128, 8'd255);
        run(10, 2'd3, 16'h0100, 8'd128, 8'd255);

        // Half-rate sawtooth, freeze, zero frequency
        do_reset(2'd0, 8'd128);
        run(10, 2'd0, 16'h8000, 8'd128, 8'd255);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 16'h8000, 8'd128, 8'd255);
        run(20, 2'd0, 16'h0000, 8'd128, 8'd255);

        // clr with en mid-period, then rst colliding with clr and a pending sel
        do_reset(2'd0, 8'd128);
        run(50, 2'd0, 16'h0100, 8'd128, 8'd255);
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 16'h0100, 8'd128, 8'd255);
        run(5, 2'd0, 16'h0100, 8'd128, 8'd255);
        run(3, 2'd1, 16'h0100, 8'd128, 8'd255);
        cyc(1'b1, 1'b1, 1'b1, 2'd1, 16'h0100, 8'd128, 8'd255);
        run(5, 2'd1, 16'h0100, 8'd128, 8'd255);

        // Amplitude scaling (ignored when the feature is compiled out)
        do_reset(2'd0, 8'd128);
        run(20, 2'd0, 16'h0100, 8'd128, 8'd128);
        run(6, 2'd0, 16'h0100, 8'd128, 8'd0);

        // Randomised traffic
        begin
            logic [1:0]  rs;
            logic [15:0] rf;
            logic [7:0]  rd, ra;
            rs = 2'd0; rf = 16'h0100; rd = 8'd128; ra = 8'd255;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 19) == 0) rs = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 29) == 0) rd = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 49) == 0) ra = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 59) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       rf = 16'($urandom_range(0, 65535));
                        1:       rf = 16'($urandom_range(1, 2047));
                        2:       rf = 16'h8000;
                        default: rf = 16'h0000;
                    endcase
                end
                cyc(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) != 0),
                    1'($urandom_range(0, 99) == 0), rs, rf, rd, ra);
            end
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain leftover=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
